// File: rtl/serial_adder_pkg.sv
// serial_adder_pkg
//   Shared definitions for the bit-serial adder:
//   - WIDTH_DEFAULT : default operand/sum width in bits
//   - state_t       : controller states IDLE / RUN / DONE
package serial_adder_pkg;

  localparam int WIDTH_DEFAULT = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/serial_adder_full_adder.sv
// full_adder
//   Gate-level one-bit full adder, used as the serial cell of serial_adder.
//   Ports:
//     a, b, cin : input  addend bits and carry-in
//     sum       : output a ^ b ^ cin
//     cout      : output majority(a, b, cin)
module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);

  logic ab_x;
  logic ab_a;
  logic cx_a;

  xor g_x0 (ab_x, a, b);
  xor g_x1 (sum, ab_x, cin);
  and g_a0 (ab_a, a, b);
  and g_a1 (cx_a, ab_x, cin);
  or  g_o0 (cout, ab_a, cx_a);

endmodule

// File: rtl/serial_adder.sv
// serial_adder
//   Bit-serial adder: latches a, b and cin, then adds one bit pair per clock
//   (LSB first) through a single full_adder cell. Result appears WIDTH cycles
//   after the accept edge and is held until the consumer takes it.
//
//   Handshake (both sides): a transfer happens on a rising edge where
//   valid && ready are both high. The producer keeps valid and data stable
//   until that edge; ready may be any function of the receiver's state.
//   Here in_ready is high only in IDLE and out_valid only in DONE, so an
//   operand transfer and a result transfer never overlap.
//
//   Ports:
//     clk, rst_n            : clock, asynchronous active-low reset
//     in_valid / in_ready   : operand handshake
//     a, b, cin             : operands and carry-in
//     out_valid / out_ready : result handshake
//     sum, cout, ovf        : registered result, carry out, signed overflow
//     busy                  : high while in RUN or DONE
//     dbg_state             : current controller state for observation
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             busy,
  output state_t           dbg_state
);

  localparam int CW = $clog2(WIDTH + 1);

  state_t state;
  state_t state_next;

  logic [WIDTH-1:0] sh_a;
  logic [WIDTH-1:0] sh_b;
  logic             carry;
  // Holds the WIDTH-1 sum bits produced so far; the newest bit enters at
  // the top so the first (LSB) bit lands in position 0 after WIDTH edges.
  logic [WIDTH-2:0] acc;
  logic [WIDTH-1:0] acc_next;
  logic [CW-1:0]    cnt;
  logic             last_bit;

  logic [WIDTH-1:0] sum_q;
  logic             cout_q;
  logic             ovf_q;

  logic             fa_sum;
  logic             fa_cout;

  full_adder u_cell (
    .a    (sh_a[0]),
    .b    (sh_b[0]),
    .cin  (carry),
    .sum  (fa_sum),
    .cout (fa_cout)
  );

  assign acc_next = {fa_sum, acc};
  assign last_bit = (cnt == CW'(WIDTH - 1));

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (in_valid) state_next = RUN;
      RUN:     if (last_bit) state_next = DONE;
      DONE:    if (out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Output decode
  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    case (state)
      IDLE:    in_ready  = 1'b1;
      RUN:     busy      = 1'b1;
      DONE: begin
        out_valid = 1'b1;
        busy      = 1'b1;
      end
      default: in_ready  = 1'b0;
    endcase
  end

  // Datapath. Result registers are only written on the final RUN edge, so
  // they stay untouched through IDLE and the following RUN.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sh_a   <= '0;
      sh_b   <= '0;
      carry  <= 1'b0;
      acc    <= '0;
      cnt    <= '0;
      sum_q  <= '0;
      cout_q <= 1'b0;
      ovf_q  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            sh_a  <= a;
            sh_b  <= b;
            carry <= cin;
            cnt   <= '0;
          end
        end
        RUN: begin
          sh_a  <= sh_a >> 1;
          sh_b  <= sh_b >> 1;
          carry <= fa_cout;
          acc   <= acc_next[WIDTH-1:1];
          // cnt tops out at WIDTH on the final edge, which CW bits can hold.
          cnt   <= cnt + CW'(1);
          if (last_bit) begin
            sum_q  <= acc_next;
            cout_q <= fa_cout;
            // carry still holds the carry into the MSB on this edge.
            ovf_q  <= fa_cout ^ carry;
          end
        end
        default: ;
      endcase
    end
  end

  assign sum       = sum_q;
  assign cout      = cout_q;
  assign ovf       = ovf_q;
  assign dbg_state = state;

endmodule

// File: tb/tb_serial_adder.sv
// tb_serial_adder
//   Directed and random checks of serial_adder at WIDTH=4.
module tb_serial_adder;
  import serial_adder_pkg::*;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         cin = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] sum;
  logic         cout;
  logic         ovf;
  logic         busy;
  state_t       dbg_state;

  int checks = 0;
  int failures = 0;

  // Expected {ovf, cout, sum}
  logic [W+1:0] exp_q[$];

  always #5 clk = ~clk;

  serial_adder #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .ovf       (ovf),
    .busy      (busy),
    .dbg_state (dbg_state)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: unsigned sum with carry, signed overflow from operand/result signs.
  function automatic logic [W+1:0] model(input logic [W-1:0] x, input logic [W-1:0] y,
                                         input logic c);
    logic [W:0] s;
    logic       v;
    s = {1'b0, x} + {1'b0, y} + {{W{1'b0}}, c};
    v = (x[W-1] == y[W-1]) && (s[W-1] != x[W-1]);
    return {v, s[W], s[W-1:0]};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic run_add(input logic [W-1:0] xa, input logic [W-1:0] xb, input logic xc,
                         input logic [W+1:0] exp_res, input int stall, input bit detail);
    logic [W+1:0] e;
    int cyc;
    check("accept_ready", 32'(in_ready), 32'(1'b1));
    a = xa;
    b = xb;
    cin = xc;
    in_valid = 1'b1;
    out_ready = (stall == 0);
    exp_q.push_back(exp_res);
    step();
    // Scramble inputs after the accept edge; none of it may be taken.
    a = W'($urandom);
    b = W'($urandom);
    cin = 1'($urandom);
    in_valid = 1'($urandom);
    cyc = 0;
    while (out_valid !== 1'b1 && cyc < 4 * W + 8) begin
      step();
      cyc++;
      a = W'($urandom);
      b = W'($urandom);
      in_valid = 1'($urandom);
    end
    in_valid = 1'b0;
    if (detail) check("latency", 32'(cyc), 32'(W));
    e = exp_q.pop_front();
    check("out_valid", 32'(out_valid), 32'(1'b1));
    check("result", 32'({ovf, cout, sum}), 32'(e));
    for (int i = 0; i < stall; i++) begin
      in_valid = 1'b1;
      step();
      check("stall_hold", 32'({out_valid, in_ready, ovf, cout, sum}), 32'({2'b10, e}));
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    step();
    if (detail) begin
      check("ret_out_valid", 32'(out_valid), 32'(1'b0));
      check("ret_in_ready", 32'(in_ready), 32'(1'b1));
      check("result_keep", 32'({ovf, cout, sum}), 32'(e));
    end
  endtask

  initial begin
    logic [W-1:0] ra;
    logic [W-1:0] rb;
    logic         rc;
    int           st;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_in_ready", 32'(in_ready), 32'(1'b1));
    check("rst_out_valid", 32'(out_valid), 32'(1'b0));
    check("rst_busy", 32'(busy), 32'(1'b0));
    check("rst_result", 32'({ovf, cout, sum}), 32'(0));
    check("rst_state", 32'(dbg_state), 32'(IDLE));
    @(negedge clk);
    rst_n = 1'b1;

    // Directed additions
    run_add(4'b0101, 4'b0011, 1'b0, 6'b10_1000, 0, 1'b1);
    run_add(4'b1111, 4'b0001, 1'b0, 6'b01_0000, 0, 1'b1);
    run_add(4'b1000, 4'b1000, 1'b0, 6'b11_0000, 0, 1'b1);
    run_add(4'b1010, 4'b0011, 1'b1, 6'b00_1110, 0, 1'b1);

    // Backpressure for 5 cycles, then new operands accepted
    run_add(4'b0111, 4'b0001, 1'b0, 6'b10_1000, 5, 1'b1);
    run_add(4'b0010, 4'b0011, 1'b0, 6'b00_0101, 0, 1'b1);

    // Reset after two RUN edges aborts the operation
    a = 4'b1111;
    b = 4'b1111;
    cin = 1'b1;
    in_valid = 1'b1;
    out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    step();
    step();
    check("pre_abort_busy", 32'(busy), 32'(1'b1));
    rst_n = 1'b0;
    #1;
    check("abort_out_valid", 32'(out_valid), 32'(1'b0));
    check("abort_busy", 32'(busy), 32'(1'b0));
    check("abort_result", 32'({ovf, cout, sum}), 32'(0));
    step();
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("release_in_ready", 32'(in_ready), 32'(1'b1));
    run_add(4'b0110, 4'b0010, 1'b0, 6'b10_1000, 0, 1'b1);

    // Random regression with random stalls
    for (int n = 0; n < 1000; n++) begin
      ra = W'($urandom);
      rb = W'($urandom);
      rc = 1'($urandom);
      st = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 4) : 0;
      run_add(ra, rb, rc, model(ra, rb, rc), st, 1'b0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/serial_adder.md
SERIAL_ADDER -- requirements
Module: serial_adder

Interface
REQ-001 Parameter: WIDTH, default 4, operand and sum width in bits; legal range 2..32.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 in_valid  input  1  operands and cin presented for a new addition.
REQ-005 in_ready  output  1  block will accept operands this cycle.
REQ-006 a  input  WIDTH  first addend, unsigned or two's complement.
REQ-007 b  input  WIDTH  second addend.
REQ-008 cin  input  1  carry-in.
REQ-009 out_valid  output  1  sum, cout and ovf are valid.
REQ-010 out_ready  input  1  consumer accepts the result this cycle.
REQ-011 sum  output  WIDTH  a+b+cin modulo 2^WIDTH.
REQ-012 cout  output  1  carry out of the MSB (unsigned overflow).
REQ-013 ovf  output  1  two's-complement overflow: carry into MSB XOR carry out of MSB.
REQ-014 busy  output  1  high in RUN or DONE.

Function
REQ-015 FSM states SHALL be IDLE, RUN and DONE.
REQ-016 in_ready SHALL be high only in IDLE.
REQ-017 IDLE: on an edge with in_valid&&in_ready, the block SHALL latch a, b and cin into internal shift/carry registers, clear the bit counter and enter RUN.
REQ-018 RUN: each edge SHALL add exactly one bit pair, LSB first, through one full-adder cell; the sum bit is shifted into the result register from the MSB side; the carry register updates.
REQ-019 After the WIDTH-th RUN edge, the FSM SHALL enter DONE; out_valid SHALL be high from that cycle, i.e. exactly WIDTH cycles after the accept edge.
REQ-020 On the final RUN edge, the carry into the MSB SHALL be captured so that ovf is computed correctly.
REQ-021 DONE: sum, cout and ovf SHALL hold stable while out_valid is high and out_ready is low (unbounded backpressure).
REQ-022 On an edge with out_valid&&out_ready, the FSM SHALL return to IDLE; out_valid falls and in_ready rises in the next cycle; results stay unchanged until the next DONE.
REQ-023 Operands and results SHALL NOT overlap; throughput is one addition per WIDTH+2 cycles with out_ready held high.
REQ-024 in_valid outside IDLE and changes on a/b/cin after the accept edge SHALL be ignored.
REQ-025 The bit counter SHALL be ceil(log2(WIDTH+1)) bits wide and SHALL never wrap in RUN.
REQ-026 In every state, sum, cout and ovf SHALL be pure register outputs with no combinational path from inputs.

Reset
REQ-027 While rst_n is low: FSM=IDLE, in_ready=1, out_valid=0, busy=0, sum=0, cout=0, ovf=0, counter=0, carry=0.
REQ-028 Reset asserted during RUN or DONE SHALL abort the operation; no partial result becomes visible after release.
REQ-029 The first accept SHALL be possible on the first rising edge after rst_n deasserts.

Structure
REQ-030 A shared package SHALL hold the FSM state enum (IDLE, RUN, DONE) and the default WIDTH constant.
REQ-031 One sub-module, full_adder (a, b, cin -> sum, cout, gate-level), SHALL be instantiated exactly once as the serial cell.

Verification (WIDTH=4)
REQ-032 a=0101, b=0011, cin=0, out_ready=1 -> after 4 cycles sum=1000, cout=0, ovf=1.
REQ-033 a=1111, b=0001, cin=0 -> sum=0000, cout=1, ovf=0; then a=1000, b=1000 -> sum=0000, cout=1, ovf=1.
REQ-034 a=1010, b=0011, cin=1 -> sum=1110, cout=0, ovf=0; out_valid high exactly 4 cycles after accept edge.
REQ-035 Result ready with out_ready low for 5 cycles -> sum/cout/ovf stable, in_ready=0, in_valid pulses ignored; out_ready=1 -> IDLE next cycle, new operands accepted.
REQ-036 rst_n low after 2 RUN edges -> immediately out_valid=0, busy=0, sum=0; after release in_ready=1; next addition 0110+0010 -> sum=1000, cout=0, ovf=1.
REQ-037 Random regression: 1000 random (a, b, cin) with random out_ready stalls -> every result equals {cout,sum}=a+b+cin and ovf matches the signed reference model.
